sample_pos_engine: RTL and testbench

SAMPLE_POS_ENGINE -- requirements
Module: sample_pos_engine

---
 rtl/sample_pos_engine_if.sv | 40 ++++
 rtl/sample_pos_engine.sv | 188 ++++++++++++++++++
 tb/tb_sample_pos_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sample_pos_engine_if.sv
// Bus bundle for the sample position engine: host write port, advance
// request port and the registered result port.
interface sample_pos_engine_if #(
  parameter int CHANNELS  = 8,
  parameter int POS_WIDTH = 16,
  parameter int INC_WIDTH = 12
);
  localparam int CH_WIDTH = $clog2(CHANNELS);

  // Host write port
  logic                 wr_en;
  logic [CH_WIDTH-1:0]  wr_chan;
  logic [POS_WIDTH-1:0] wr_data;

  // Advance request port (one request per cycle, never stalled)
  logic                 adv_valid;
  logic [CH_WIDTH-1:0]  adv_chan;
  logic [INC_WIDTH-1:0] adv_inc;
  logic [POS_WIDTH-1:0] adv_limit;

  // Result port
  logic                 pos_valid;
  logic [CH_WIDTH-1:0]  pos_chan;
  logic [POS_WIDTH-1:0] pos_out;
  logic                 wrapped;

  // Requester side: drives writes and advances, observes results
  modport master (
    output wr_en, wr_chan, wr_data,
    output adv_valid, adv_chan, adv_inc, adv_limit,
    input  pos_valid, pos_chan, pos_out, wrapped
  );

  // Engine side
  modport slave (
    input  wr_en, wr_chan, wr_data,
    input  adv_valid, adv_chan, adv_inc, adv_limit,
    output pos_valid, pos_chan, pos_out, wrapped
  );
endinterface

// File: rtl/sample_pos_engine.sv
// Multi-channel sample position engine. Each channel keeps a looping
// position; an advance adds an increment and wraps against a loop limit.
// Two-stage pipeline: stage 1 captures the request and the old position,
// stage 2 computes, writes back and registers the result. Same-channel
// back-to-back advances are forwarded so they accumulate; a host write
// always wins over both the stored value and the forwarded result.
module sample_pos_engine #(
  parameter int CHANNELS  = 8,
  parameter int POS_WIDTH = 16,
  parameter int INC_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sample_pos_engine_if.slave    bus
);
  localparam int CH_WIDTH  = $clog2(CHANNELS);
  localparam int SUM_WIDTH = POS_WIDTH + 1;

  // Wrap rule: {wrapped, new_position}. A zero limit, or an overshoot of
  // more than a full loop, collapses to position 0 with wrapped set.
  function automatic logic [POS_WIDTH:0] advance_calc(
    input logic [POS_WIDTH-1:0] old_pos,
    input logic [INC_WIDTH-1:0] inc,
    input logic [POS_WIDTH-1:0] limit
  );
    logic [SUM_WIDTH-1:0] sum;
    logic [SUM_WIDTH-1:0] lim_x;
    logic [SUM_WIDTH-1:0] over;
    logic [POS_WIDTH:0]   result;
    sum   = {1'b0, old_pos} + {{(SUM_WIDTH-INC_WIDTH){1'b0}}, inc};
    lim_x = {1'b0, limit};
    over  = sum - lim_x;
    if (limit == {POS_WIDTH{1'b0}}) begin
      result = {1'b1, {POS_WIDTH{1'b0}}};
    end else if (sum < lim_x) begin
      result = {1'b0, sum[POS_WIDTH-1:0]};
    end else if (over >= lim_x) begin
      result = {1'b1, {POS_WIDTH{1'b0}}};
    end else begin
      result = {1'b1, over[POS_WIDTH-1:0]};
    end
    return result;
  endfunction

  // Position storage (no reset; the init vector masks stale contents)
  logic [POS_WIDTH-1:0] mem_q [CHANNELS];
  logic [CHANNELS-1:0]  init_q;
  logic [CHANNELS-1:0]  init_d;

  // Stage 1
  logic                 s1_valid_q;
  logic [CH_WIDTH-1:0]  s1_chan_q;
  logic [INC_WIDTH-1:0] s1_inc_q;
  logic [POS_WIDTH-1:0] s1_limit_q;
  logic [POS_WIDTH-1:0] s1_old_q;
  logic [POS_WIDTH-1:0] s1_old_d;

  // Stage 2 compute
  logic [POS_WIDTH:0]   calc_s;
  logic [POS_WIDTH-1:0] new_s;
  logic                 wrap_s;
  logic                 host_hits_wb_s;

  // Registered outputs
  logic                 pos_valid_q;
  logic [CH_WIDTH-1:0]  pos_chan_q;
  logic [CH_WIDTH-1:0]  pos_chan_d;
  logic [POS_WIDTH-1:0] pos_out_q;
  logic [POS_WIDTH-1:0] pos_out_d;
  logic                 wrapped_q;
  logic                 wrapped_d;

  // Stage 2 arithmetic on the captured request
  always_comb begin
    calc_s = advance_calc(s1_old_q, s1_inc_q, s1_limit_q);
    new_s  = calc_s[POS_WIDTH-1:0];
    wrap_s = calc_s[POS_WIDTH];
  end

  // Host write to the channel being written back suppresses the writeback
  always_comb begin
    host_hits_wb_s = bus.wr_en && s1_valid_q && (bus.wr_chan == s1_chan_q);
  end

  // Old-position select: host write, then in-flight result, then memory
  always_comb begin
    s1_old_d = {POS_WIDTH{1'b0}};
    if (bus.wr_en && (bus.wr_chan == bus.adv_chan)) begin
      s1_old_d = bus.wr_data;
    end else if (s1_valid_q && (s1_chan_q == bus.adv_chan)) begin
      s1_old_d = new_s;
    end else if (init_q[bus.adv_chan]) begin
      s1_old_d = mem_q[bus.adv_chan];
    end else begin
      s1_old_d = {POS_WIDTH{1'b0}};
    end
  end

  // Init bits: set by writeback and by host write
  always_comb begin
    init_d = init_q;
    if (s1_valid_q) begin
      init_d[s1_chan_q] = 1'b1;
    end else begin
      init_d = init_q;
    end
    if (bus.wr_en) begin
      init_d[bus.wr_chan] = 1'b1;
    end else begin
      init_d = init_d;
    end
  end

  // Result register next-state: update on a completing advance, else hold
  always_comb begin
    pos_chan_d = pos_chan_q;
    pos_out_d  = pos_out_q;
    wrapped_d  = wrapped_q;
    if (s1_valid_q) begin
      pos_chan_d = s1_chan_q;
      pos_out_d  = new_s;
      wrapped_d  = wrap_s;
    end else begin
      pos_chan_d = pos_chan_q;
      pos_out_d  = pos_out_q;
      wrapped_d  = wrapped_q;
    end
  end

  // Position memory writes; host data overrides a same-channel writeback
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_q[bus.wr_chan] <= bus.wr_data;
    end
    if (s1_valid_q && !host_hits_wb_s) begin
      mem_q[s1_chan_q] <= new_s;
    end
  end

  // Init vector register, cleared by reset so every channel reads zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q <= {CHANNELS{1'b0}};
    end else begin
      init_q <= init_d;
    end
  end

  // Stage 1 capture; reset drops any in-flight request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_chan_q  <= {CH_WIDTH{1'b0}};
      s1_inc_q   <= {INC_WIDTH{1'b0}};
      s1_limit_q <= {POS_WIDTH{1'b0}};
      s1_old_q   <= {POS_WIDTH{1'b0}};
    end else begin
      s1_valid_q <= bus.adv_valid;
      if (bus.adv_valid) begin
        s1_chan_q  <= bus.adv_chan;
        s1_inc_q   <= bus.adv_inc;
        s1_limit_q <= bus.adv_limit;
        s1_old_q   <= s1_old_d;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_valid_q <= 1'b0;
      pos_chan_q  <= {CH_WIDTH{1'b0}};
      pos_out_q   <= {POS_WIDTH{1'b0}};
      wrapped_q   <= 1'b0;
    end else begin
      pos_valid_q <= s1_valid_q;
      pos_chan_q  <= pos_chan_d;
      pos_out_q   <= pos_out_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign bus.pos_valid = pos_valid_q;
  assign bus.pos_chan  = pos_chan_q;
  assign bus.pos_out   = pos_out_q;
  assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_sample_pos_engine.sv
// Self-checking bench for sample_pos_engine: directed scenarios plus
// randomized traffic, compared against a sequential per-channel model.
module tb_sample_pos_engine;
  localparam int CH = 8;
  localparam int PW = 16;
  localparam int IW = 12;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  sample_pos_engine_if #(.CHANNELS(CH), .POS_WIDTH(PW), .INC_WIDTH(IW)) bus ();

  sample_pos_engine #(.CHANNELS(CH), .POS_WIDTH(PW), .INC_WIDTH(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: current position per channel, the advance still in flight,
  // and the last result shown on the output port.
  int ref_pos [CH];
  bit pend_v;
  int pend_c, pend_n, pend_w;
  int last_c, last_n, last_w;
  int obs_c, obs_n, obs_w;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Loop position rule written as plain integer arithmetic
  function automatic void model_adv(input int old_pos, input int inc, input int lim,
                                    output int new_pos, output int wrap);
    int sum;
    sum = old_pos + inc;
    if (lim == 0) begin
      new_pos = 0; wrap = 1;
    end else if (sum < lim) begin
      new_pos = sum; wrap = 0;
    end else if (sum - lim < lim) begin
      new_pos = sum - lim; wrap = 1;
    end else begin
      new_pos = 0; wrap = 1;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) ref_pos[i] = 0;
    pend_v = 1'b0;
    last_c = 0; last_n = 0; last_w = 0;
  endtask

  // One clock: drive inputs, take the edge, check outputs, advance the model
  task automatic step(input bit we, input int wc, input int wd,
                      input bit av, input int ac, input int ai, input int al);
    int n, w;
    bus.wr_en     = we;
    bus.wr_chan   = wc[2:0];
    bus.wr_data   = wd[15:0];
    bus.adv_valid = av;
    bus.adv_chan  = ac[2:0];
    bus.adv_inc   = ai[11:0];
    bus.adv_limit = al[15:0];
    @(posedge clk);
    #1;
    obs_c = int'(bus.pos_chan);
    obs_n = int'(bus.pos_out);
    obs_w = int'(bus.wrapped);
    check_val("pos_valid", {31'd0, bus.pos_valid}, {31'd0, pend_v});
    if (pend_v) begin
      last_c = pend_c; last_n = pend_n; last_w = pend_w;
    end
    check_val("pos_chan", obs_c, last_c);
    check_val("pos_out", obs_n, last_n);
    check_val("wrapped", obs_w, last_w);
    if (pend_v) ref_pos[pend_c] = pend_n;
    if (we) ref_pos[wc] = wd;
    if (av) begin
      model_adv(ref_pos[ac], ai, al, n, w);
      pend_v = 1'b1; pend_c = ac; pend_n = n; pend_w = w;
    end else begin
      pend_v = 1'b0;
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic adv(input int c, input int inc, input int lim);
    step(1'b0, 0, 0, 1'b1, c, inc, lim);
  endtask

  task automatic hwr(input int c, input int d);
    step(1'b1, c, d, 1'b0, 0, 0, 0);
  endtask

  initial begin
    int lim, mode;
    reset_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_chan = 3'd0; bus.wr_data = 16'd0;
    bus.adv_valid = 1'b0; bus.adv_chan = 3'd0; bus.adv_inc = 12'd0; bus.adv_limit = 16'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", {31'd0, bus.pos_valid}, 32'd0);
    check_val("rst_out", {16'd0, bus.pos_out}, 32'd0);
    check_val("rst_wrapped", {31'd0, bus.wrapped}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // First request after reset, latency two edges
    adv(3, 100, 1000);
    idle();
    check_val("basic_chan", obs_c, 3);
    check_val("basic_out", obs_n, 100);
    check_val("basic_wrap", obs_w, 0);

    // Host write then wrap past the limit
    hwr(1, 950);
    adv(1, 100, 1000);
    idle();
    check_val("wrap_out", obs_n, 50);
    check_val("wrap_flag", obs_w, 1);

    // Back-to-back same channel accumulates
    adv(2, 10, 1000);
    adv(2, 10, 1000);
    check_val("fwd_1", obs_n, 10);
    adv(2, 10, 1000);
    check_val("fwd_2", obs_n, 20);
    idle();
    check_val("fwd_3", obs_n, 30);

    // Host write collides with writeback: output shows computed, memory keeps host
    adv(5, 40, 1000);
    hwr(5, 500);
    check_val("hostwb_out", obs_n, 40);
    adv(5, 1, 1000);
    idle();
    check_val("hostwb_next", obs_n, 501);

    // Host write collides with stage-1 capture of the same channel
    adv(4, 7, 1000);
    step(1'b1, 4, 300, 1'b1, 4, 5, 1000);
    idle();
    check_val("hostcap_out", obs_n, 305);

    // Zero limit and overshoot past a full loop
    adv(0, 7, 0);
    idle();
    check_val("lim0_out", obs_n, 0);
    check_val("lim0_wrap", obs_w, 1);
    hwr(6, 5);
    adv(6, 4095, 10);
    idle();
    check_val("over_out", obs_n, 0);
    check_val("over_wrap", obs_w, 1);

    // Randomized traffic with frequent channel collisions
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: lim = 0;
        1: lim = $urandom_range(1, 64);
        2: lim = $urandom_range(1000, 5000);
        default: lim = $urandom_range(1, 65535);
      endcase
      step(($urandom_range(0, 4) == 0), $urandom_range(0, CH-1), $urandom_range(0, 65535),
           ($urandom_range(0, 9) < 7), $urandom_range(0, CH-1), $urandom_range(0, 4095), lim);
    end
    idle();
    idle();

    // Reset with two advances in flight
    adv(1, 11, 1000);
    adv(2, 22, 1000);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("midrst_valid", {31'd0, bus.pos_valid}, 32'd0);
    check_val("midrst_out", {16'd0, bus.pos_out}, 32'd0);
    check_val("midrst_chan", {29'd0, bus.pos_chan}, 32'd0);
    model_reset();
    bus.adv_valid = 1'b0;
    bus.wr_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) idle();
    for (int c = 0; c < CH; c++) begin
      adv(c, 0, 65535);
    end
    idle();
    idle();
    check_val("postrst_last", obs_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
